// File: rtl/div_if.sv
// Request/response bundle between the execute stage and the divider.
// The divider side also exposes its FSM state for observation.
interface div_if;
    logic [31:0] div_data1_i;
    logic [31:0] div_data2_i;
    logic        div_signed_i;
    logic        div_start_i;
    logic        div_cancel_i;
    logic [63:0] div_result_o;
    logic        div_done_o;
    logic [1:0]  div_state_o;

    modport master (
        output div_data1_i, div_data2_i, div_signed_i, div_start_i, div_cancel_i,
        input  div_result_o, div_done_o, div_state_o
    );

    modport slave (
        input  div_data1_i, div_data2_i, div_signed_i, div_start_i, div_cancel_i,
        output div_result_o, div_done_o, div_state_o
    );
endinterface

// File: rtl/div.sv
// Multi-cycle 32-bit integer divider: radix-2 restoring division on operand
// magnitudes, one quotient bit per cycle, signs restored on completion.
module div (
    input  logic clk,
    input  logic rst,
    div_if.slave bus
);
    // Handshake: the requester raises div_start_i with stable operands and holds
    // it until div_done_o pulses for one cycle; result is valid in that cycle.
    // Dropping start or raising cancel while busy abandons the operation.
    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

    state_t      state_q, state_nxt;
    logic [31:0] dividend_q, dividend_nxt;
    logic [31:0] divisor_q, divisor_nxt;
    logic [31:0] rem_q, rem_nxt;
    logic [31:0] quot_q, quot_nxt;
    logic [4:0]  count_q, count_nxt;
    logic        qneg_q, qneg_nxt;
    logic        rneg_q, rneg_nxt;
    logic [63:0] result_q, result_nxt;
    logic        done_q, done_nxt;

    logic [31:0] abs1, abs2;
    logic [32:0] rem33;
    logic [31:0] rem_step, quot_step, rem_fix, quot_fix;

    // Magnitudes; 0x8000_0000 negates to itself and is read as unsigned 2^31.
    assign abs1 = (bus.div_signed_i && bus.div_data1_i[31]) ? (32'd0 - bus.div_data1_i)
                                                            : bus.div_data1_i;
    assign abs2 = (bus.div_signed_i && bus.div_data2_i[31]) ? (32'd0 - bus.div_data2_i)
                                                            : bus.div_data2_i;

    assign rem33     = {rem_q, dividend_q[31]} - {1'b0, divisor_q};
    assign rem_step  = rem33[32] ? {rem_q[30:0], dividend_q[31]} : rem33[31:0];
    assign quot_step = {quot_q[30:0], ~rem33[32]};
    assign quot_fix  = qneg_q ? (32'd0 - quot_step) : quot_step;
    assign rem_fix   = rneg_q ? (32'd0 - rem_step) : rem_step;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            dividend_q <= 32'd0;
            divisor_q  <= 32'd0;
            rem_q      <= 32'd0;
            quot_q     <= 32'd0;
            count_q    <= 5'd0;
            qneg_q     <= 1'b0;
            rneg_q     <= 1'b0;
            result_q   <= 64'd0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_nxt;
            dividend_q <= dividend_nxt;
            divisor_q  <= divisor_nxt;
            rem_q      <= rem_nxt;
            quot_q     <= quot_nxt;
            count_q    <= count_nxt;
            qneg_q     <= qneg_nxt;
            rneg_q     <= rneg_nxt;
            result_q   <= result_nxt;
            done_q     <= done_nxt;
        end
    end

    always_comb begin
        state_nxt    = state_q;
        dividend_nxt = dividend_q;
        divisor_nxt  = divisor_q;
        rem_nxt      = rem_q;
        quot_nxt     = quot_q;
        count_nxt    = count_q;
        qneg_nxt     = qneg_q;
        rneg_nxt     = rneg_q;
        result_nxt   = result_q;
        done_nxt     = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.div_start_i && !bus.div_cancel_i) begin
                    if (bus.div_data2_i == 32'd0) begin
                        // Divide by zero: raw dividend as remainder, all-ones quotient.
                        result_nxt = {bus.div_data1_i, 32'hFFFF_FFFF};
                        done_nxt   = 1'b1;
                        state_nxt  = DONE;
                    end else begin
                        dividend_nxt = abs1;
                        divisor_nxt  = abs2;
                        qneg_nxt     = bus.div_signed_i & (bus.div_data1_i[31] ^ bus.div_data2_i[31]);
                        rneg_nxt     = bus.div_signed_i & bus.div_data1_i[31];
                        rem_nxt      = 32'd0;
                        quot_nxt     = 32'd0;
                        count_nxt    = 5'd0;
                        state_nxt    = BUSY;
                    end
                end
            end
            BUSY: begin
                if (bus.div_cancel_i || !bus.div_start_i) begin
                    state_nxt = IDLE;
                end else begin
                    dividend_nxt = {dividend_q[30:0], 1'b0};
                    rem_nxt      = rem_step;
                    quot_nxt     = quot_step;
                    count_nxt    = count_q + 5'd1;
                    if (count_q == 5'd31) begin
                        result_nxt = {rem_fix, quot_fix};
                        done_nxt   = 1'b1;
                        state_nxt  = DONE;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign bus.div_result_o = result_q;
    assign bus.div_done_o   = done_q;
    assign bus.div_state_o  = state_q;
endmodule

// File: tb/tb_div.sv
// Directed bench for the divider: vector table for single operations plus
// hand-written back-to-back, abort and reset sequences.
module tb_div;
    logic clk;
    logic rst;
    div_if bus ();

    div dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] d1;
        logic [31:0] d2;
        logic        sgn;
        logic [63:0] exp;
        int          lat;
    } vec_t;

    vec_t        vecs[14];
    logic [63:0] exp_q[$];
    int          checks;
    int          failures;
    int          cyc;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drive(input logic [31:0] d1, input logic [31:0] d2, input logic sgn);
        bus.div_data1_i  = d1;
        bus.div_data2_i  = d2;
        bus.div_signed_i = sgn;
    endtask

    task automatic run_op(input vec_t v);
        logic        got;
        int          lat;
        logic [63:0] res;
        got = 1'b0;
        lat = 0;
        res = 64'd0;
        cyc = 0;
        drive(v.d1, v.d2, v.sgn);
        bus.div_start_i = 1'b1;
        exp_q.push_back(v.exp);
        while (!got && cyc < 100) begin
            tick();
            if (bus.div_done_o) begin
                got = 1'b1;
                lat = cyc;
                res = bus.div_result_o;
                bus.div_start_i = 1'b0;
            end
        end
        bus.div_start_i = 1'b0;
        if (!got) begin
            check({v.name, "_timeout"}, 64'd0, 64'd1);
            void'(exp_q.pop_front());
        end else begin
            check({v.name, "_latency"}, 64'(lat), 64'(v.lat));
            check({v.name, "_result"}, res, exp_q.pop_front());
        end
        tick();
        check({v.name, "_done_low"}, 64'(bus.div_done_o), 64'd0);
    endtask

    // Abort at cycle k by cancel (start held) or by dropping start, then restart 8/3.
    task automatic abort_seq(input string name, input int k, input logic use_cancel,
                             input logic [63:0] prev_res);
        logic got;
        int   done_cyc;
        int   restart;
        logic [63:0] res;
        got = 1'b0;
        done_cyc = -1;
        res = 64'd0;
        restart = use_cancel ? k + 2 : k + 1;
        cyc = 0;
        drive(32'd100, 32'd7, 1'b0);
        bus.div_start_i = 1'b1;
        while (!got && cyc < 150) begin
            tick();
            if (bus.div_done_o) begin
                got = 1'b1;
                done_cyc = cyc;
                res = bus.div_result_o;
                bus.div_start_i = 1'b0;
            end else begin
                if (cyc == k) begin
                    if (use_cancel) bus.div_cancel_i = 1'b1;
                    else            bus.div_start_i  = 1'b0;
                end
                if (cyc == k + 1) begin
                    bus.div_cancel_i = 1'b0;
                    bus.div_start_i  = 1'b0;
                    check({name, "_idle_after_abort"}, 64'(bus.div_state_o), 64'd0);
                    check({name, "_result_kept"}, bus.div_result_o, prev_res);
                end
                if (cyc == restart) begin
                    drive(32'd8, 32'd3, 1'b0);
                    bus.div_start_i = 1'b1;
                end
            end
        end
        bus.div_start_i = 1'b0;
        check({name, "_done_cycle"}, 64'(done_cyc), 64'(restart + 33));
        check({name, "_result"}, res, {32'd2, 32'd2});
        tick();
    endtask

    initial begin
        logic [31:0] b2b_d1[2];
        logic [31:0] b2b_d2[2];
        int          b2b_done[2];
        int          idx;
        int          extra;
        logic [63:0] res;

        checks   = 0;
        failures = 0;
        cyc      = 0;

        vecs[0]  = '{"u100_7",      32'd100,        32'd7,          1'b0, {32'd2, 32'd14},                  33};
        vecs[1]  = '{"s_m7_2",      32'hFFFF_FFF9,  32'd2,          1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD},   33};
        vecs[2]  = '{"s_7_m2",      32'd7,          32'hFFFF_FFFE,  1'b1, {32'd1, 32'hFFFF_FFFD},           33};
        vecs[3]  = '{"s_ovf",       32'h8000_0000,  32'hFFFF_FFFF,  1'b1, {32'd0, 32'h8000_0000},           33};
        vecs[4]  = '{"u_ovf_ops",   32'h8000_0000,  32'hFFFF_FFFF,  1'b0, {32'h8000_0000, 32'd0},           33};
        vecs[5]  = '{"u_max_1",     32'hFFFF_FFFF,  32'd1,          1'b0, {32'd0, 32'hFFFF_FFFF},           33};
        vecs[6]  = '{"s_dz",        32'd1234,       32'd0,          1'b1, {32'd1234, 32'hFFFF_FFFF},        1};
        vecs[7]  = '{"u_dz",        32'd1234,       32'd0,          1'b0, {32'd1234, 32'hFFFF_FFFF},        1};
        vecs[8]  = '{"s_m8_dz",     32'hFFFF_FFF8,  32'd0,          1'b1, {32'hFFFF_FFF8, 32'hFFFF_FFFF},   1};
        vecs[9]  = '{"s_m100_7",    32'hFFFF_FF9C,  32'd7,          1'b1, {32'hFFFF_FFFE, 32'hFFFF_FFF2},   33};
        vecs[10] = '{"s_100_m7",    32'd100,        32'hFFFF_FFF9,  1'b1, {32'd2, 32'hFFFF_FFF2},           33};
        vecs[11] = '{"s_0_5",       32'd0,          32'd5,          1'b1, {32'd0, 32'd0},                   33};
        vecs[12] = '{"u_5_7",       32'd5,          32'd7,          1'b0, {32'd5, 32'd0},                   33};
        vecs[13] = '{"u_max_16",    32'hFFFF_FFFF,  32'd16,         1'b0, {32'hF, 32'h0FFF_FFFF},           33};

        rst = 1'b1;
        drive(32'd0, 32'd0, 1'b0);
        bus.div_start_i  = 1'b0;
        bus.div_cancel_i = 1'b0;
        repeat (3) tick();
        check("reset_done", 64'(bus.div_done_o), 64'd0);
        check("reset_result", bus.div_result_o, 64'd0);
        check("reset_state", 64'(bus.div_state_o), 64'd0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 14; i++) run_op(vecs[i]);

        // EX model: start = pending & ~done, two divides back to back.
        b2b_d1[0] = 32'd50; b2b_d2[0] = 32'd5;
        b2b_d1[1] = 32'd9;  b2b_d2[1] = 32'd4;
        b2b_done[0] = -1;   b2b_done[1] = -1;
        exp_q.push_back({32'd0, 32'd10});
        exp_q.push_back({32'd1, 32'd2});
        idx = 0;
        cyc = 0;
        drive(b2b_d1[0], b2b_d2[0], 1'b0);
        bus.div_start_i = 1'b1;
        while (idx < 2 && cyc < 200) begin
            tick();
            if (bus.div_done_o) begin
                b2b_done[idx] = cyc;
                check("b2b_result", bus.div_result_o, exp_q.pop_front());
                idx++;
                if (idx < 2) drive(b2b_d1[idx], b2b_d2[idx], 1'b0);
            end
            bus.div_start_i = (idx < 2) && !bus.div_done_o;
        end
        bus.div_start_i = 1'b0;
        check("b2b_done0_cycle", 64'(b2b_done[0]), 64'd33);
        check("b2b_done1_cycle", 64'(b2b_done[1]), 64'd67);
        extra = 0;
        repeat (40) begin
            tick();
            if (bus.div_done_o) extra++;
        end
        check("b2b_no_extra_done", 64'(extra), 64'd0);

        abort_seq("cancel", 10, 1'b1, {32'd1, 32'd2});
        abort_seq("start_drop", 5, 1'b0, {32'd2, 32'd2});

        // Reset in the middle of an operation.
        cyc = 0;
        drive(32'd100, 32'd7, 1'b0);
        bus.div_start_i = 1'b1;
        extra = 0;
        while (cyc < 20) begin
            tick();
            if (bus.div_done_o) extra++;
        end
        rst = 1'b1;
        bus.div_start_i = 1'b0;
        tick();
        res = bus.div_result_o;
        check("rst_mid_done", 64'(bus.div_done_o), 64'd0);
        check("rst_mid_result", res, 64'd0);
        check("rst_mid_state", 64'(bus.div_state_o), 64'd0);
        rst = 1'b0;
        repeat (60) begin
            tick();
            if (bus.div_done_o) extra++;
        end
        check("rst_no_done", 64'(extra), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
